// File: rtl/commit_watchdog_if.sv
// rtl/commit_watchdog_if.sv - retirement stream and monitor inputs observed by the commit watchdog
interface commit_watchdog_if #(
  parameter int NUM_CH   = 2,
  parameter int PC_WIDTH = 32
);
  logic [NUM_CH-1:0]          commit_valid;
  logic [NUM_CH*PC_WIDTH-1:0] commit_pc;
  logic                       ext_halt;
  logic [15:0]                err_code;

  // Core / monitor side drives the stream
  modport master (
    output commit_valid,
    output commit_pc,
    output ext_halt,
    output err_code
  );

  // Watchdog side only observes it
  modport slave (
    input commit_valid,
    input commit_pc,
    input ext_halt,
    input err_code
  );
endinterface

// File: rtl/commit_watchdog.sv
// rtl/commit_watchdog.sv - halt/livelock watchdog deciding when a multi-commit core simulation ends
module commit_watchdog #(
  parameter int              NUM_CH         = 2,
  parameter int              PC_WIDTH       = 32,
  parameter int              CNT_W          = 32,
  parameter int              LOOP_LIMIT     = 2047,
  parameter int              STALL_LIMIT    = 100000,
  parameter int              TIMEOUT_CYCLES = 100000000,
  parameter int              DRAIN_CYCLES   = 5,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = 32'h00000060
) (
  input  logic               clk,
  input  logic               rst_n,
  commit_watchdog_if.slave   cw,
  output logic               halt,
  output logic [2:0]         halt_reason,
  output logic [15:0]        err_latched,
  output logic               loop_halt,
  output logic [CNT_W-1:0]   commit_count
);

  localparam int LOOP_W  = $clog2(LOOP_LIMIT + 1);
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [LOOP_W-1:0]  LOOP_MAX   = LOOP_W'(LOOP_LIMIT);
  localparam logic [CNT_W-1:0]   STALL_MAX  = CNT_W'(STALL_LIMIT);
  localparam logic [CNT_W-1:0]   TIMER_INIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  localparam logic [2:0] R_EXT     = 3'd1;
  localparam logic [2:0] R_ERROR   = 3'd2;
  localparam logic [2:0] R_LOOP    = 3'd3;
  localparam logic [2:0] R_STALL   = 3'd4;
  localparam logic [2:0] R_TIMEOUT = 3'd5;

  logic [1:0]          r_state;
  logic                r_halt;
  logic [2:0]          r_reason;
  logic [15:0]         r_err;
  logic                r_loop_halt;
  logic [CNT_W-1:0]    r_commit_cnt;
  logic [PC_WIDTH-1:0] r_last_pc;
  logic [LOOP_W-1:0]   r_loop_cnt;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    r_timer;
  logic [DRAIN_W-1:0]  r_drain_cnt;

  logic [PC_WIDTH-1:0] w_last_pc_next;
  logic [LOOP_W-1:0]   w_loop_next;
  logic [CNT_W:0]      w_pop;
  logic [CNT_W:0]      w_sum;
  logic [CNT_W-1:0]    w_commit_next;
  logic [CNT_W-1:0]    w_stall_next;
  logic [CNT_W-1:0]    w_timer_next;
  logic                w_trig_loop;
  logic                w_trig_stall;
  logic                w_trig_timeout;

  // Fold the same-PC run length across channels oldest-first and count this cycle's retirements
  always_comb begin
    w_last_pc_next = r_last_pc;
    w_loop_next    = r_loop_cnt;
    w_pop          = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cw.commit_valid[i]) begin
        if (cw.commit_pc[i*PC_WIDTH +: PC_WIDTH] == w_last_pc_next) begin
          w_loop_next = (w_loop_next >= LOOP_MAX) ? LOOP_MAX : w_loop_next + 1'b1;
        end else begin
          w_loop_next = '0;
        end
        w_last_pc_next = cw.commit_pc[i*PC_WIDTH +: PC_WIDTH];
        w_pop = w_pop + 1'b1;
      end
    end
  end

  // Saturating next values for the commit, stall and timeout counters, plus trigger detection
  always_comb begin
    w_sum          = {1'b0, r_commit_cnt} + w_pop;
    w_commit_next  = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
    if (|cw.commit_valid) begin
      w_stall_next = '0;
    end else begin
      w_stall_next = (r_stall_cnt == STALL_MAX) ? r_stall_cnt : r_stall_cnt + 1'b1;
    end
    w_timer_next   = (r_timer == '0) ? '0 : r_timer - 1'b1;
    w_trig_loop    = (w_loop_next == LOOP_MAX);
    w_trig_stall   = (w_stall_next == STALL_MAX);
    w_trig_timeout = (w_timer_next == '0);
  end

  // Loop tracking runs in every state so the monitor can see loop_halt even while draining
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_pc   <= RESET_PC;
      r_loop_cnt  <= '0;
      r_loop_halt <= 1'b0;
    end else begin
      r_last_pc  <= w_last_pc_next;
      r_loop_cnt <= w_loop_next;
      if (w_trig_loop) begin
        r_loop_halt <= 1'b1;
      end
    end
  end

  // Run/drain/halted sequencing with prioritised halt causes; counters freeze once halted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_RUN;
      r_halt       <= 1'b0;
      r_reason     <= 3'd0;
      r_err        <= 16'd0;
      r_commit_cnt <= '0;
      r_stall_cnt  <= '0;
      r_timer      <= TIMER_INIT;
      r_drain_cnt  <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          r_commit_cnt <= w_commit_next;
          r_stall_cnt  <= w_stall_next;
          r_timer      <= w_timer_next;
          if (cw.ext_halt) begin
            r_state  <= S_HALT;
            r_halt   <= 1'b1;
            r_reason <= R_EXT;
          end else if (cw.err_code != 16'd0) begin
            r_state     <= S_DRAIN;
            r_err       <= cw.err_code;
            r_drain_cnt <= '0;
          end else if (w_trig_loop) begin
            r_state  <= S_HALT;
            r_halt   <= 1'b1;
            r_reason <= R_LOOP;
          end else if (w_trig_stall) begin
            r_state  <= S_HALT;
            r_halt   <= 1'b1;
            r_reason <= R_STALL;
          end else if (w_trig_timeout) begin
            r_state  <= S_HALT;
            r_halt   <= 1'b1;
            r_reason <= R_TIMEOUT;
          end
        end
        S_DRAIN: begin
          r_commit_cnt <= w_commit_next;
          r_stall_cnt  <= w_stall_next;
          r_timer      <= w_timer_next;
          if (r_drain_cnt == DRAIN_LAST) begin
            r_state  <= S_HALT;
            r_halt   <= 1'b1;
            r_reason <= R_ERROR;
          end else begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_RUN;
        end
      endcase
    end
  end

  assign halt         = r_halt;
  assign halt_reason  = r_reason;
  assign err_latched  = r_err;
  assign loop_halt    = r_loop_halt;
  assign commit_count = r_commit_cnt;

endmodule
